// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
//   db_state_t : per-channel filter state (two stable levels, two qualifying waits)
//   cnt_width  : stability counter width for a given qualification length
package debounce_pkg;

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} db_state_t;

  function automatic int cnt_width(int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-channel debouncer: input synchroniser, four-state filter FSM with a
// stability counter, and registered level/strobe outputs.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   noisy     : raw asynchronous input
//   debounced : filtered level
//   rise/fall : one-cycle strobes on debounced 0->1 / 1->0
//   busy      : high while a candidate edge is being qualified
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic noisy,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned     CW        = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CntLast   = CW'(DEBOUNCE_CYCLES - 1);
  localparam db_state_t       InitState = INIT_LEVEL ? STABLE_HI : STABLE_LO;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_now, wait_now;
  logic                   debounced_q, rise_q, fall_q, busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A reversal in a WAIT state is tested before count completion so that the
  // candidate is rejected even on the final qualifying cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      STABLE_LO: if (s) state_d = WAIT_HI;
      WAIT_HI: begin
        if (!s)                  state_d = STABLE_LO;
        else if (cnt_q == CntLast) state_d = STABLE_HI;
        else                     cnt_d = cnt_q + CW'(1);
      end
      STABLE_HI: if (!s) state_d = WAIT_LO;
      WAIT_LO: begin
        if (s)                   state_d = STABLE_HI;
        else if (cnt_q == CntLast) state_d = STABLE_LO;
        else                     cnt_d = cnt_q + CW'(1);
      end
      default: state_d = InitState;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= InitState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_now = (state_q == STABLE_HI) || (state_q == WAIT_LO);
  assign wait_now  = (state_q == WAIT_HI) || (state_q == WAIT_LO);

  // Strobes are derived from the registered level so they coincide exactly
  // with the cycle debounced changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debounced_q <= INIT_LEVEL;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      debounced_q <= level_now;
      rise_q      <= level_now & ~debounced_q;
      fall_q      <= ~level_now & debounced_q;
      busy_q      <= wait_now;
    end
  end

  assign debounced = debounced_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign busy      = busy_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel switch/button debouncer; one independent debounce_channel per bit.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   noisy     : raw asynchronous inputs, bit i = channel i
//   debounced : filtered level per channel
//   rise/fall : one-cycle strobes per channel on debounced 0->1 / 1->0
//   busy      : per channel, high while qualifying a candidate edge
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          INIT_LEVEL      = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] noisy,
  output logic [NUM_CH-1:0] debounced,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] busy
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES),
      .INIT_LEVEL     (INIT_LEVEL)
    ) u_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .noisy    (noisy[i]),
      .debounced(debounced[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus a randomized
// run compared against a run-length reference model of the filter rules.
module tb_debounce_multi;

  localparam int NUM_CH = 4;
  localparam int D      = 8;
  localparam int S      = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] noisy = '0;
  logic [NUM_CH-1:0] debounced, rise, fall, busy;
  logic [NUM_CH-1:0] noisy1 = '1;
  logic [NUM_CH-1:0] debounced1, rise1, fall1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .noisy(noisy),
    .debounced(debounced), .rise(rise), .fall(fall), .busy(busy)
  );

  debounce_multi #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .INIT_LEVEL(1'b1)
  ) dut_hi (
    .clk(clk), .rst_n(rst_n), .noisy(noisy1),
    .debounced(debounced1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  // Reference model: a level is accepted once the synchronised input has
  // disagreed with the accepted level for D+1 consecutive samples; outputs
  // show the accepted level one cycle later.
  logic [NUM_CH-1:0] m_dly [S];
  logic [NUM_CH-1:0] m_lvl, m_up, m_dn;
  logic [NUM_CH-1:0] exp_deb, exp_rise, exp_fall, exp_busy;
  int                m_run [NUM_CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) m_dly[k] <= '0;
      m_lvl    <= '0;
      m_up     <= '0;
      m_dn     <= '0;
      exp_deb  <= '0;
      exp_rise <= '0;
      exp_fall <= '0;
      exp_busy <= '0;
      for (int i = 0; i < NUM_CH; i++) m_run[i] <= 0;
    end else begin
      m_dly[0] <= noisy;
      for (int k = 1; k < S; k++) m_dly[k] <= m_dly[k-1];
      exp_deb  <= m_lvl;
      exp_rise <= m_up;
      exp_fall <= m_dn;
      for (int i = 0; i < NUM_CH; i++) begin
        exp_busy[i] <= (m_run[i] != 0);
        if (m_dly[S-1][i] != m_lvl[i]) begin
          if (m_run[i] == D) begin
            m_lvl[i] <= m_dly[S-1][i];
            m_up[i]  <= m_dly[S-1][i];
            m_dn[i]  <= ~m_dly[S-1][i];
            m_run[i] <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
            m_up[i]  <= 1'b0;
            m_dn[i]  <= 1'b0;
          end
        end else begin
          m_run[i] <= 0;
          m_up[i]  <= 1'b0;
          m_dn[i]  <= 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    noisy = 4'hF;
    repeat (3) @(negedge clk);
    checks++; if (debounced !== 4'h0) begin errors++; $display("FAIL reset_deb: got %h want 0", debounced); end
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL reset_rise: got %h want 0", rise); end
    checks++; if (fall !== 4'h0) begin errors++; $display("FAIL reset_fall: got %h want 0", fall); end
    checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
    rst_n = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 5) begin
        checks++; if (busy !== 4'hF) begin errors++; $display("FAIL rel_busy: got %h want f", busy); end
      end
      if (n == 11) begin
        checks++; if (debounced !== 4'h0) begin errors++; $display("FAIL rel_deb_early: got %h want 0", debounced); end
      end
      if (n == 12) begin
        checks++; if (debounced !== 4'hF) begin errors++; $display("FAIL rel_deb: got %h want f", debounced); end
        checks++; if (rise !== 4'hF) begin errors++; $display("FAIL rel_rise: got %h want f", rise); end
      end
      if (n == 13) begin
        checks++; if (rise !== 4'h0) begin errors++; $display("FAIL rel_rise_once: got %h want 0", rise); end
      end
    end
    noisy = 4'h0;
    repeat (14) @(negedge clk);
    checks++; if (debounced !== 4'h0) begin errors++; $display("FAIL rel_back_lo: got %h want 0", debounced); end
  endtask

  task automatic test_glitch();
    int busy_seen = 0, deb_seen = 0, rise_cnt = 0, rise_at = 0;
    noisy[0] = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (busy[0]) busy_seen = 1;
      if (debounced[0]) deb_seen = 1;
      if (rise[0]) rise_cnt++;
      if (n == 5) noisy[0] = 1'b0;
    end
    checks++; if (busy_seen != 1) begin errors++; $display("FAIL glitch_busy: got %0d want 1", busy_seen); end
    checks++; if (deb_seen != 0) begin errors++; $display("FAIL glitch_deb: got %0d want 0", deb_seen); end
    checks++; if (rise_cnt != 0) begin errors++; $display("FAIL glitch_rise: got %0d want 0", rise_cnt); end
    noisy[0] = 1'b1;
    rise_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rise[0]) begin rise_cnt++; rise_at = n; end
    end
    checks++; if (rise_cnt != 1) begin errors++; $display("FAIL hold_rise_cnt: got %0d want 1", rise_cnt); end
    checks++; if (rise_at != 12) begin errors++; $display("FAIL hold_rise_at: got %0d want 12", rise_at); end
    checks++; if (debounced[0] !== 1'b1) begin errors++; $display("FAIL hold_deb: got %b want 1", debounced[0]); end
    noisy[0] = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_boundary();
    for (int len = D; len <= D + 1; len++) begin
      int rise_cnt = 0, fall_at = 0;
      logic busy11 = 1'b0, busy12 = 1'b0, deb12 = 1'b0;
      noisy[0] = 1'b1;
      for (int n = 1; n <= 30; n++) begin
        @(negedge clk);
        if (rise[0]) rise_cnt++;
        if (fall[0]) fall_at = n;
        if (n == 11) busy11 = busy[0];
        if (n == 12) begin busy12 = busy[0]; deb12 = debounced[0]; end
        if (n == len) noisy[0] = 1'b0;
      end
      checks++; if (rise_cnt != ((len > D) ? 1 : 0)) begin
        errors++; $display("FAIL bound_rise len=%0d: got %0d want %0d", len, rise_cnt, (len > D) ? 1 : 0);
      end
      checks++; if (busy11 !== 1'b1) begin errors++; $display("FAIL bound_busy11 len=%0d: got %b want 1", len, busy11); end
      checks++; if (deb12 !== (len > D)) begin
        errors++; $display("FAIL bound_deb12 len=%0d: got %b want %b", len, deb12, len > D);
      end
      checks++; if (busy12 !== 1'b0) begin errors++; $display("FAIL bound_busy12 len=%0d: got %b want 0", len, busy12); end
      checks++; if (fall_at != ((len > D) ? len + 12 : 0)) begin
        errors++; $display("FAIL bound_fall_at len=%0d: got %0d want %0d", len, fall_at, (len > D) ? len + 12 : 0);
      end
      checks++; if (debounced[0] !== 1'b0) begin errors++; $display("FAIL bound_end len=%0d: got %b want 0", len, debounced[0]); end
    end
  endtask

  task automatic test_independence();
    int rise1_at = 0, fall2_at = 0, other = 0;
    noisy[2] = 1'b1;
    repeat (14) @(negedge clk);
    noisy[1] = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (rise[1]) rise1_at = n;
      if (fall[2]) fall2_at = n;
      if (rise[0] | fall[0] | rise[3] | fall[3] | debounced[0] | debounced[3]) other++;
      if (n == 3) noisy[2] = 1'b0;
    end
    checks++; if (rise1_at != 12) begin errors++; $display("FAIL indep_rise1: got %0d want 12", rise1_at); end
    checks++; if (fall2_at != 15) begin errors++; $display("FAIL indep_fall2: got %0d want 15", fall2_at); end
    checks++; if (other != 0) begin errors++; $display("FAIL indep_other: got %0d want 0", other); end
    checks++; if (debounced !== 4'b0010) begin errors++; $display("FAIL indep_deb: got %b want 0010", debounced); end
    noisy[1] = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rise_at = 0, rise_cnt = 0;
    noisy[3] = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b want 1", busy[3]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 4'h0) begin errors++; $display("FAIL mid_busy_clr: got %h want 0", busy); end
    checks++; if ((debounced | rise | fall) !== 4'h0) begin
      errors++; $display("FAIL mid_outs_clr: got deb=%h rise=%h fall=%h want 0", debounced, rise, fall);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (rise[3]) begin rise_at = n; rise_cnt++; end
    end
    checks++; if (rise_at != 12 || rise_cnt != 1) begin
      errors++; $display("FAIL mid_restart: got at=%0d cnt=%0d want at=12 cnt=1", rise_at, rise_cnt);
    end
    noisy[3] = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++; if (debounced !== exp_deb) begin errors++; $display("FAIL rnd_deb c=%0d: got %h want %h", c, debounced, exp_deb); end
      checks++; if (rise !== exp_rise) begin errors++; $display("FAIL rnd_rise c=%0d: got %h want %h", c, rise, exp_rise); end
      checks++; if (fall !== exp_fall) begin errors++; $display("FAIL rnd_fall c=%0d: got %h want %h", c, fall, exp_fall); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy c=%0d: got %h want %h", c, busy, exp_busy); end
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 10) == 0) noisy[i] = ~noisy[i];
      end
    end
    noisy = '0;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_init_high();
    int rise_cnt = 0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (debounced1 !== 4'hF) begin errors++; $display("FAIL hi_reset_deb: got %h want f", debounced1); end
    checks++; if ((rise1 | fall1 | busy1) !== 4'h0) begin
      errors++; $display("FAIL hi_reset_strobes: got rise=%h fall=%h busy=%h want 0", rise1, fall1, busy1);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (rise1 != 4'h0) rise_cnt++;
    end
    checks++; if (rise_cnt != 0) begin errors++; $display("FAIL hi_no_rise: got %0d want 0", rise_cnt); end
    noisy1 = 4'h0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 11) begin
        checks++; if (debounced1 !== 4'hF) begin errors++; $display("FAIL hi_deb_early: got %h want f", debounced1); end
      end
      if (n == 12) begin
        checks++; if (fall1 !== 4'hF) begin errors++; $display("FAIL hi_fall: got %h want f", fall1); end
        checks++; if (debounced1 !== 4'h0) begin errors++; $display("FAIL hi_deb: got %h want 0", debounced1); end
      end
      if (n == 13) begin
        checks++; if (fall1 !== 4'h0) begin errors++; $display("FAIL hi_fall_once: got %h want 0", fall1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_boundary();
    test_independence();
    test_reset_mid();
    test_random();
    test_init_high();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel switch/button debouncer; successor to the single-channel fixed-timer debouncer.
- Each channel has a configurable synchroniser, an independent four-state filter FSM and a per-channel stability counter.
- Outputs the clean level plus single-cycle rise/fall event strobes.
- Sits between raw board inputs (buttons, switches, UART-adjacent control lines) and synchronous control logic.

Parameters:
- NUM_CH, 4, number of independent input channels (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised cycles required to accept a new level (>=2).
- SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2).
- INIT_LEVEL, 0, level every channel's debounced output and filter state take in reset (0 or 1).

Ports:
- clk  input  1  system clock; all state updates on posedge clk only.
- rst_n  input  1  asynchronous active-low reset.
- noisy  input  NUM_CH  raw asynchronous inputs, bit i = channel i.
- debounced  output  NUM_CH  filtered level per channel.
- rise  output  NUM_CH  one-cycle strobe when debounced[i] goes 0->1.
- fall  output  NUM_CH  one-cycle strobe when debounced[i] goes 1->0.
- busy  output  NUM_CH  1 while channel i is in a WAIT state (qualifying a candidate edge).

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - synchroniser flops = INIT_LEVEL; state = STABLE_HI if INIT_LEVEL else STABLE_LO; counter = 0.
  - debounced = INIT_LEVEL; rise = fall = busy = 0.
- Reset release: takes effect on the next posedge.
- Reset asserted mid-count: aborts the count and clears it immediately, with no rise/fall strobe.
- Synchroniser: noisy[i] passes through SYNC_STAGES flops; the last stage is s[i]. The FSM sees only s[i].
- Counter: width CW = $clog2(DEBOUNCE_CYCLES). Per channel, it clears to 0 in the STABLE states and increments by 1 per cycle in the WAIT states. It never wraps, because the exit condition fires at DEBOUNCE_CYCLES-1.
- FSM per channel; the states are STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: s=1 -> WAIT_HI with cnt=0; else stay.
  - WAIT_HI: s=0 -> STABLE_LO with cnt cleared and no strobe. Else if cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI. Else cnt++.
  - STABLE_HI: s=0 -> WAIT_LO with cnt=0; else stay.
  - WAIT_LO: s=1 -> STABLE_HI with cnt cleared. Else if cnt==DEBOUNCE_CYCLES-1 -> STABLE_LO. Else cnt++.
  - In a WAIT state, a level reversal takes priority over count completion on the same cycle; the candidate is rejected.
- Outputs are registered:
  - debounced = 1 in STABLE_HI and WAIT_LO; 0 in STABLE_LO and WAIT_HI.
  - busy = 1 in WAIT_HI and WAIT_LO.
  - rise = 1 for exactly the one cycle after the WAIT_HI->STABLE_HI transition.
  - fall = 1 for exactly the one cycle after the WAIT_LO->STABLE_LO transition.
  - rise and fall are never both 1 on one channel.
- Latency: if noisy[i] changes and then holds, debounced[i] changes SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles after the first posedge sampling the new level.
- Glitch rejection:
  - A synchronised pulse shorter than DEBOUNCE_CYCLES+1 cycles produces no output change.
  - A glitch restarts qualification from cnt=0 on its next occurrence.
- Channels are fully independent. Simultaneous edges on several channels each qualify and strobe on their own timelines.
- Timer: the single-clock-edge design rule applies; there is no negedge logic and no blocking assignments in clocked processes.

Decomposition:
- debounce_pkg holds:
  - typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} db_state_t;
  - function cnt_width(int cycles) returning $clog2(cycles).
- Sub-module debounce_channel: one synchroniser, FSM and counter, plus registered debounced/rise/fall/busy for one bit.
- debounce_multi is a generate loop over NUM_CH instances of debounce_channel.

Test Plan (NUM_CH=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2, INIT_LEVEL=0 unless stated):
- Reset: hold rst_n=0 with noisy=4'hF -> debounced=0, rise=fall=busy=0. Release, then hold noisy=4'hF -> debounced=4'hF exactly 11 cycles after the first sampling edge, and rise=4'hF for one cycle only.
- Glitch: noisy[0] high for 5 cycles, then low -> busy[0] pulses, debounced[0] stays 0, rise[0] never asserts. Then hold high for 20 cycles -> rise[0] fires once, 11 cycles after the second rising sample.
- Boundary: a synchronised high lasting exactly DEBOUNCE_CYCLES cycles -> rejected. DEBOUNCE_CYCLES+1 cycles -> accepted. Check the reversal-priority cycle.
- Independence: channel 1 rising while channel 2 falls (from STABLE_HI), with channel 2 offset by 3 cycles -> rise[1] and fall[2] strobe 3 cycles apart; channels 0 and 3 stay unchanged.
- Reset mid-operation: assert rst_n=0 asynchronously (between edges) when channel 3 has cnt=5 in WAIT_HI -> outputs clear immediately with no strobe. After release, qualification restarts from 0.
- INIT_LEVEL=1: after reset, debounced=4'hF with no rise. Drive noisy=0 stable -> fall=4'hF once after 11 cycles, then debounced=0.
